// File: rtl/word_ser_pkg.sv
// Shared definitions for the word serializer: default geometry and the
// IDLE/SEND state type used to give the remaining-byte counter a readable name.
package word_ser_pkg;

    localparam int BYTE_W_DEF    = 8;
    localparam int NUM_BYTES_DEF = 4;

    // The state is derived from the remaining-byte count, not stored separately.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial byte transmitter: accepts one word per valid/ready
// handshake and streams it out MSB byte first, one byte per byte handshake.
// The last byte of a word can overlap the load of the next word, so a
// continuous producer and consumer see no bubble between words.
module word_serializer
    import word_ser_pkg::*;
#(
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter int NUM_BYTES = NUM_BYTES_DEF   // must be at least 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BYTE_W*NUM_BYTES-1:0] word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output logic [BYTE_W-1:0]           byte_out,
    output logic                        byte_valid,
    input  logic                        byte_ready,
    output logic                        byte_last,
    output logic                        busy
);

    localparam int WORD_W = BYTE_W * NUM_BYTES;
    localparam int CNT_W  = $clog2(NUM_BYTES + 1);

    localparam logic [CNT_W-1:0] REM_ZERO = '0;
    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] REM_FULL = CNT_W'(NUM_BYTES);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  rem_q,  rem_d;
    state_t            state;
    logic              word_hs;
    logic              byte_hs;

    // Name the counter's two regions: nothing pending versus a word in flight.
    always_comb begin
        state = (rem_q == REM_ZERO) ? ST_IDLE : ST_SEND;
    end

    // Outputs come straight from the registers; word_ready also looks at
    // byte_ready so the final byte and the next load share one edge.
    always_comb begin
        byte_out   = sreg_q[WORD_W-1 -: BYTE_W];
        byte_valid = (state == ST_SEND);
        byte_last  = (rem_q == REM_ONE);
        busy       = byte_valid;
        word_ready = !reset && ((state == ST_IDLE) || (byte_last && byte_ready));
        word_hs    = word_valid && word_ready;
        byte_hs    = byte_valid && byte_ready;
    end

    // Next shift-register and counter values; a load wins over a shift
    // because the only overlap is on the last byte, which is being dropped.
    always_comb begin
        sreg_d = sreg_q;
        rem_d  = rem_q;
        if (word_hs) begin
            sreg_d = word_in;
            rem_d  = REM_FULL;
        end else if (byte_hs) begin
            sreg_d = sreg_q << BYTE_W;   // zero fill leaves byte_out at 0 when idle
            rem_d  = rem_q - REM_ONE;
        end
    end

    // State registers; reset discards any partially sent word immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
            rem_q  <= REM_ZERO;
        end else begin
            sreg_q <= sreg_d;
            rem_q  <= rem_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Testbench for word_serializer: directed scenarios plus a randomized run
// checked against a byte-queue reference model.
module tb_word_serializer;

    localparam int BW = 8;
    localparam int NB = 4;
    localparam int WW = BW * NB;

    logic          clk = 1'b0;
    logic          reset;
    logic [WW-1:0] word_in;
    logic          word_valid;
    logic          word_ready;
    logic [BW-1:0] byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic          byte_last;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    word_serializer #(.BYTE_W(BW), .NUM_BYTES(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset      = 1'b1;
        word_in    = 32'hA5A5A5A5;
        word_valid = 1'b1;
        byte_ready = 1'b1;
        #1;
        if ({byte_valid, byte_last, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {byte_valid, byte_last, busy});
        end
        checks++;
        if (byte_out !== 8'h00) begin
            failures++; $display("FAIL reset_byte_out got=%h exp=00", byte_out);
        end
        checks++;
        @(posedge clk); @(posedge clk); #1;
        word_valid = 1'b0;
        if (byte_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ignores_hs got=%b exp=0", byte_valid);
        end
        checks++;
        reset = 1'b0;
        #1;
        if (word_ready !== 1'b1) begin
            failures++; $display("FAIL reset_word_ready got=%b exp=1", word_ready);
        end
        checks++;
        @(posedge clk); #1;
        if (byte_valid !== 1'b0) begin
            failures++; $display("FAIL reset_stays_idle got=%b exp=0", byte_valid);
        end
        checks++;
    endtask

    task automatic test_single();
        logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        word_in = 32'hDEADBEEF; word_valid = 1'b1; byte_ready = 1'b1;
        @(negedge clk);
        if (word_ready !== 1'b1) begin
            failures++; $display("FAIL single_accept got=%b exp=1", word_ready);
        end
        checks++;
        @(posedge clk); #1;
        word_valid = 1'b0; word_in = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({byte_valid, busy, byte_out} !== {2'b11, exp_b[i]}) begin
                failures++; $display("FAIL single_byte%0d got=%b/%b/%h exp=1/1/%h", i, byte_valid, busy, byte_out, exp_b[i]);
            end
            checks++;
            if (byte_last !== (i == 3)) begin
                failures++; $display("FAIL single_last%0d got=%b exp=%b", i, byte_last, (i == 3));
            end
            checks++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        if ({byte_valid, busy, byte_out} !== 10'h0) begin
            failures++; $display("FAIL single_idle got=%b/%b/%h exp=0/0/00", byte_valid, busy, byte_out);
        end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        word_in = 32'h01020304; word_valid = 1'b1; byte_ready = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        @(negedge clk);
        if (byte_out !== 8'h01) begin
            failures++; $display("FAIL bp_first got=%h exp=01", byte_out);
        end
        checks++;
        @(posedge clk); #1;
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({byte_valid, byte_last, word_ready, byte_out} !== {3'b100, 8'h02}) begin
                failures++; $display("FAIL bp_stall%0d got=v%b l%b wr%b %h exp=v1 l0 wr0 02", i, byte_valid, byte_last, word_ready, byte_out);
            end
            checks++;
            @(posedge clk); #1;
        end
        byte_ready = 1'b1;
        @(negedge clk);
        if ({byte_valid, byte_out} !== {1'b1, 8'h02}) begin
            failures++; $display("FAIL bp_release got=%b/%h exp=1/02", byte_valid, byte_out);
        end
        checks++;
        @(posedge clk); #1;
        @(negedge clk);
        if ({byte_valid, byte_last, byte_out} !== {2'b10, 8'h03}) begin
            failures++; $display("FAIL bp_third got=%b/%b/%h exp=1/0/03", byte_valid, byte_last, byte_out);
        end
        checks++;
        @(posedge clk); #1;
        @(negedge clk);
        if ({byte_valid, byte_last, byte_out} !== {2'b11, 8'h04}) begin
            failures++; $display("FAIL bp_fourth got=%b/%b/%h exp=1/1/04", byte_valid, byte_last, byte_out);
        end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        word_in = 32'h11223344; word_valid = 1'b1; byte_ready = 1'b1;
        @(posedge clk); #1;
        word_in = 32'hAABBCCDD;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ({byte_valid, byte_out} !== {1'b1, exp_b[i]}) begin
                failures++; $display("FAIL b2b_byte%0d got=%b/%h exp=1/%h", i, byte_valid, byte_out, exp_b[i]);
            end
            checks++;
            if ({byte_last, word_ready} !== {(i % 4 == 3), (i % 4 == 3)}) begin
                failures++; $display("FAIL b2b_ctl%0d got=last%b wr%b exp=last%b wr%b", i, byte_last, word_ready, (i % 4 == 3), (i % 4 == 3));
            end
            checks++;
            @(posedge clk); #1;
            if (i == 3) word_valid = 1'b0;
        end
        @(negedge clk);
        if (byte_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_idle got=%b exp=0", byte_valid);
        end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_reject();
        logic [7:0] exp_b [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        word_in = 32'h12345678; word_valid = 1'b1; byte_ready = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin word_in = 32'hFFFFFFFF; word_valid = 1'b1; end
            @(negedge clk);
            if ({byte_valid, byte_out} !== {1'b1, exp_b[i]}) begin
                failures++; $display("FAIL busy_byte%0d got=%b/%h exp=1/%h", i, byte_valid, byte_out, exp_b[i]);
            end
            checks++;
            if (i >= 1 && i <= 3 && word_ready !== (i == 3)) begin
                failures++; $display("FAIL busy_wr%0d got=%b exp=%b", i, word_ready, (i == 3));
            end
            if (i >= 1 && i <= 3) checks++;
            @(posedge clk); #1;
            if (i == 3) word_valid = 1'b0;
        end
        @(negedge clk);
        if (byte_valid !== 1'b0) begin
            failures++; $display("FAIL busy_idle got=%b exp=0", byte_valid);
        end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        word_in = 32'hDEADBEEF; word_valid = 1'b1; byte_ready = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        if (byte_out !== 8'hAD) begin
            failures++; $display("FAIL rst_mid_pre got=%h exp=AD", byte_out);
        end
        checks++;
        #1 reset = 1'b1;
        #1;
        if ({byte_valid, busy, byte_last, byte_out} !== 11'h0) begin
            failures++; $display("FAIL rst_mid_async got=%b/%b/%b/%h exp=0/0/0/00", byte_valid, busy, byte_last, byte_out);
        end
        checks++;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        if (byte_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_stays_idle got=%b exp=0", byte_valid);
        end
        checks++;
        word_in = 32'hCAFEF00D; word_valid = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({byte_valid, byte_last, byte_out} !== {1'b1, (i == 3), exp_b[i]}) begin
                failures++; $display("FAIL rst_mid_next%0d got=%b/%b/%h exp=1/%b/%h", i, byte_valid, byte_last, byte_out, (i == 3), exp_b[i]);
            end
            checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_loopback();
        logic [WW-1:0] q_all = '0;
        int n = 0;
        word_in = 32'h89ABCDEF; word_valid = 1'b1; byte_ready = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        for (int c = 0; c < 8 && n < NB; c++) begin
            @(negedge clk);
            if (byte_valid && byte_ready) begin
                q_all = {q_all[WW-BW-1:0], byte_out};
                n++;
            end
            @(posedge clk); #1;
        end
        if (q_all !== 32'h89ABCDEF) begin
            failures++; $display("FAIL loopback got=%h exp=89ABCDEF (bytes=%0d)", q_all, n);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [7:0]    q [$];
        logic [WW-1:0] pend = '0;
        bit            have = 1'b0;
        logic          exp_bv, exp_bl, exp_wr;
        logic [7:0]    exp_bo;
        for (int c = 0; c < 600; c++) begin
            if (!have && ($urandom_range(0, 1) == 1)) begin
                have = 1'b1;
                pend = $urandom;
            end
            word_valid = have;
            word_in    = have ? pend : $urandom;
            byte_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            exp_bv = (q.size() != 0);
            exp_bo = exp_bv ? q[0] : 8'h00;
            exp_bl = (q.size() == 1);
            exp_wr = (q.size() == 0) || (q.size() == 1 && byte_ready);
            if ({byte_valid, busy, byte_last, byte_out} !== {exp_bv, exp_bv, exp_bl, exp_bo}) begin
                failures++; $display("FAIL rand_out c%0d got=v%b b%b l%b %h exp=v%b b%b l%b %h", c, byte_valid, busy, byte_last, byte_out, exp_bv, exp_bv, exp_bl, exp_bo);
            end
            checks++;
            if (word_ready !== exp_wr) begin
                failures++; $display("FAIL rand_wr c%0d got=%b exp=%b", c, word_ready, exp_wr);
            end
            checks++;
            @(posedge clk);
            if (exp_bv && byte_ready) void'(q.pop_front());
            if (have && exp_wr) begin
                q.delete();
                for (int b = NB - 1; b >= 0; b--) q.push_back(pend[b*BW +: BW]);
                have = 1'b0;
            end
            #1;
        end
        word_valid = 1'b0;
        byte_ready = 1'b1;
        for (int c = 0; c < NB + 1; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        if ({byte_valid, byte_out} !== 9'h0) begin
            failures++; $display("FAIL rand_drain got=%b/%h exp=0/00", byte_valid, byte_out);
        end
        checks++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_busy_reject();
        test_reset_mid();
        test_loopback();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
